// File: rtl/uart_receiver.sv
// uart_receiver: oversampled serial-to-parallel UART receiver.
// Frame: start bit (0), DATA_BITS data bits LSB first, stop bit (1); line idles high.
// Each bit is sampled at its midpoint, counting OVERSAMPLE boudTick strobes per bit.
// Optional build macro UART_RX_FRAME_ERR_EN: adds the frameErr output and rejects
// frames whose stop sample is 0. Without it, every frame that reaches the stop
// sample is accepted.
module uart_receiver #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boudTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 rxDone,
`ifdef UART_RX_FRAME_ERR_EN
    output logic                 frameErr,
`endif
    output logic                 rxBusy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    rxState_t             state;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bitCount;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 rxMeta;
    logic                 rxS;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
        end
    end

    // Frame FSM with counters and registered outputs; counters move only on boudTick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick     <= '0;
            bitCount <= '0;
            shiftReg <= '0;
            dataOut  <= '0;
            rxDone   <= 1'b0;
            rxBusy   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frameErr <= 1'b0;
`endif
        end else begin
            rxDone <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frameErr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxS) begin
                        state  <= START;
                        tick   <= '0;
                        rxBusy <= 1'b1;
                    end
                end
                START: begin
                    if (boudTick) begin
                        if (tick == TICK_MID) begin
                            if (!rxS) begin
                                state    <= DATA;
                                tick     <= '0;
                                bitCount <= '0;
                            end else begin
                                // Start bit gone by mid-bit: treat as a glitch.
                                state  <= IDLE;
                                rxBusy <= 1'b0;
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (boudTick) begin
                        if (tick == TICK_LAST) begin
                            shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                            tick     <= '0;
                            if (bitCount == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bitCount <= bitCount + BIT_W'(1);
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (boudTick) begin
                        if (tick == TICK_LAST) begin
                            state  <= IDLE;
                            tick   <= '0;
                            rxBusy <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                            if (rxS) begin
                                dataOut <= shiftReg;
                                rxDone  <= 1'b1;
                            end else begin
                                frameErr <= 1'b1;
                            end
`else
                            dataOut <= shiftReg;
                            rxDone  <= 1'b1;
`endif
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    rxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against uart_receiver with hand-computed bytes.
module tb_uart_receiver;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;

    logic                 clk;
    logic                 rst;
    logic                 boudTick;
    logic                 rx;
    logic [DATA_BITS-1:0] dataOut;
    logic                 rxDone;
    logic                 rxBusy;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 frameErr;
`endif

    int assertCount;
    int failCount;
    int doneCount;
    int errCount;
    int doubleDone;
    logic prevDone;
    logic [DATA_BITS-1:0] rxLog[$];

    uart_receiver #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .boudTick (boudTick),
        .rx       (rx),
        .dataOut  (dataOut),
        .rxDone   (rxDone),
`ifdef UART_RX_FRAME_ERR_EN
        .frameErr (frameErr),
`endif
        .rxBusy   (rxBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample strobe: one clock high out of every four.
    initial begin
        boudTick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            boudTick = 1'b1;
            @(negedge clk);
            boudTick = 1'b0;
        end
    end

    // Output monitor sampled on the falling edge.
    initial begin
        doneCount  = 0;
        errCount   = 0;
        doubleDone = 0;
        prevDone   = 1'b0;
        forever begin
            @(negedge clk);
            if (rxDone) begin
                doneCount++;
                rxLog.push_back(dataOut);
            end
            if (rxDone && prevDone) doubleDone++;
            prevDone = rxDone;
`ifdef UART_RX_FRAME_ERR_EN
            if (frameErr) errCount++;
`endif
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for n strobes as seen at the rising edge, then move to the falling edge.
    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!boudTick);
        end
        @(negedge clk);
    endtask

    // One frame; stopTicks lets a short low stop bit end before the restart sample.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int stopTicks);
        rx = 1'b0;
        waitTicks(OVERSAMPLE);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitTicks(OVERSAMPLE);
        end
        rx = stopBit;
        waitTicks(stopTicks);
        rx = 1'b1;
    endtask

    int base;

    initial begin
        assertCount = 0;
        failCount   = 0;
        rx  = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("reset_dataOut", 32'(dataOut), 32'h00);
        checkEq("reset_rxDone", 32'(rxDone), 32'h0);
        checkEq("reset_rxBusy", 32'(rxBusy), 32'h0);
        rst = 1'b1;

        // Idle line
        repeat (400) @(negedge clk);
        checkEq("idle_dataOut", 32'(dataOut), 32'h00);
        checkEq("idle_doneCount", 32'(doneCount), 32'd0);
        checkEq("idle_rxBusy", 32'(rxBusy), 32'h0);

        // Single frame 0xA5, busy checked mid-frame
        base = doneCount;
        fork
            sendFrame(8'hA5, 1'b1, OVERSAMPLE);
            begin
                waitTicks(40);
                checkEq("a5_busy_mid", 32'(rxBusy), 32'h1);
            end
        join
        waitTicks(4);
        checkEq("a5_doneCount", 32'(doneCount - base), 32'd1);
        checkEq("a5_dataOut", 32'(dataOut), 32'hA5);
        checkEq("a5_rxBusy", 32'(rxBusy), 32'h0);
        checkEq("a5_single_pulse", 32'(doubleDone), 32'd0);

        // Back-to-back 0x00 then 0xFF
        rxLog.delete();
        base = doneCount;
        sendFrame(8'h00, 1'b1, OVERSAMPLE);
        sendFrame(8'hFF, 1'b1, OVERSAMPLE);
        waitTicks(4);
        checkEq("b2b_doneCount", 32'(doneCount - base), 32'd2);
        checkEq("b2b_first", (rxLog.size() > 0) ? 32'(rxLog[0]) : 32'hDEAD, 32'h00);
        checkEq("b2b_second", (rxLog.size() > 1) ? 32'(rxLog[1]) : 32'hDEAD, 32'hFF);
        checkEq("b2b_dataOut", 32'(dataOut), 32'hFF);

        // 5-tick low glitch, then 0x3C
        base = doneCount;
        rx = 1'b0;
        waitTicks(5);
        rx = 1'b1;
        waitTicks(20);
        checkEq("glitch_rxBusy", 32'(rxBusy), 32'h0);
        checkEq("glitch_noDone", 32'(doneCount - base), 32'd0);
        sendFrame(8'h3C, 1'b1, OVERSAMPLE);
        waitTicks(4);
        checkEq("glitch_next_done", 32'(doneCount - base), 32'd1);
        checkEq("glitch_next_data", 32'(dataOut), 32'h3C);

        // 0x55 with a low stop bit (held past the stop sample only)
        base = doneCount;
        sendFrame(8'h55, 1'b0, 10);
        waitTicks(24);
`ifdef UART_RX_FRAME_ERR_EN
        checkEq("ferr_count", 32'(errCount), 32'd1);
        checkEq("ferr_noDone", 32'(doneCount - base), 32'd0);
        checkEq("ferr_dataHeld", 32'(dataOut), 32'h3C);
`else
        checkEq("nostop_done", 32'(doneCount - base), 32'd1);
        checkEq("nostop_data", 32'(dataOut), 32'h55);
        checkEq("nostop_errCount", 32'(errCount), 32'd0);
`endif
        checkEq("nostop_rxBusy", 32'(rxBusy), 32'h0);
        checkEq("nostop_single_pulse", 32'(doubleDone), 32'd0);

        // Reset during data bit 4 of 0x81, then 0x7E
        base = doneCount;
        rx = 1'b0;
        waitTicks(OVERSAMPLE);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h81 >> i) & 8'h01) != 0;
            waitTicks(OVERSAMPLE);
        end
        rx = 1'b0;
        waitTicks(8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("midrst_dataOut", 32'(dataOut), 32'h00);
        checkEq("midrst_rxBusy", 32'(rxBusy), 32'h0);
        checkEq("midrst_rxDone", 32'(rxDone), 32'h0);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        waitTicks(40);
        checkEq("midrst_noDone", 32'(doneCount - base), 32'd0);
        sendFrame(8'h7E, 1'b1, OVERSAMPLE);
        waitTicks(4);
        checkEq("after_rst_done", 32'(doneCount - base), 32'd1);
        checkEq("after_rst_data", 32'(dataOut), 32'h7E);
        checkEq("after_rst_busy", 32'(rxBusy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver. Pairs with the team's uart_transmitter on the same baud-tick generator.
- Frame: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1). Line idles high.
- Oversamples rx at OVERSAMPLE ticks per bit and samples each bit at its midpoint.
- Delivers each byte on dataOut with a one-clock rxDone pulse to the processor-side UART wrapper.

Parameters:
- DATA_BITS, 8, number of data bits per frame; dataOut width.
- OVERSAMPLE, 16, boudTick pulses per bit period; must be an even power of two ≥ 4.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- boudTick  input  1  one-clk-wide oversample strobe, OVERSAMPLE per bit.
- rx  input  1  asynchronous serial line.
- dataOut  output  DATA_BITS  last correctly received byte.
- rxDone  output  1  one-clk pulse when dataOut is updated.
- rxBusy  output  1  high whenever the state is not idle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=idle; tick and bit counters=0; shift register=0.
  - dataOut=0, rxDone=0, rxBusy=0.
  - Synchronizer flops reset to 1.
- Input sync: rx passes through a 2-flop synchronizer; rxS is the second flop. All decisions use rxS.
- Tick counter: log2(OVERSAMPLE) bits. It advances only on cycles with boudTick=1. Bit counter: ceil(log2(DATA_BITS)) bits.
- FSM states: idle, start, data, stop.
- idle:
  - When rxS==0: go to start, tick=0.
  - boudTick is not required to leave idle.
- start:
  - On boudTick with tick==OVERSAMPLE/2-1, sample the mid start bit.
  - If rxS==0: go to data, tick=0, bitCount=0.
  - If rxS==1: treat as a glitch; return to idle with no output.
  - On other boudTick cycles: tick+1.
- data:
  - On boudTick with tick==OVERSAMPLE-1: shift rxS into the MSB of the shift register (right shift, LSB first); tick=0.
  - If bitCount==DATA_BITS-1: go to stop. Otherwise bitCount+1.
  - On other boudTick cycles: tick+1.
- stop:
  - On boudTick with tick==OVERSAMPLE-1: sample rxS, then go to idle.
  - Acceptance rule is set by the Optional Feature.
  - On accept: dataOut←shift register and rxDone=1 for exactly the next clock.
- Sampling points: data and stop bits are sampled ~OVERSAMPLE ticks after the previous midpoint. Total frame time ≈ (DATA_BITS+1.5)×OVERSAMPLE ticks from the start edge.
- Latency: rxDone rises on the clock edge after the clock carrying the stop-sample boudTick. dataOut is valid in the same cycle as rxDone and is held until the next accepted frame.
- rxDone is registered and never asserted on two consecutive clocks.
- boudTick=0 freezes all counters. rx changes between ticks are ignored except for the idle start detect.
- Line held low (break): the frame completes with stop sample 0. The FSM returns to idle and immediately restarts on rxS==0. No hang.
- Reset mid-frame: everything is cleared. Any partial byte is discarded and no rxDone is produced.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - Adds output port frameErr (1 bit, reset 0).
  - Stop sample 0 → no dataOut update, no rxDone; frameErr pulses for one clk, same timing as rxDone.
  - Stop sample 1 → normal accept.
- Undefined:
  - No frameErr port.
  - Every frame that reaches the stop sample is accepted regardless of the stop bit value.

Test Plan:
- Reset then idle line (rx=1, boudTick every 4 clks, 400 clks) → dataOut=0x00, rxDone never high, rxBusy=0.
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), 16 ticks/bit → one rxDone pulse 1 clk wide, dataOut=0xA5, rxBusy back to 0.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two rxDone pulses; dataOut=0x00 then 0xFF.
- Low glitch of 5 ticks on idle rx → return to idle at the mid-start sample; no rxDone; next frame 0x3C received correctly.
- Frame 0x55 with stop bit=0 → with UART_RX_FRAME_ERR_EN: frameErr pulse, no rxDone, dataOut keeps its previous value. Without it: rxDone and dataOut=0x55.
- Assert rst during data bit 4 of 0x81, release, then send 0x7E → outputs cleared at reset; only rxDone with dataOut=0x7E follows.
